core_sequencer: RTL

Multi-cycle control sequencer for the single-issue RV32I subset core (R-type, I-ALU, load, store, branch). It steps the shared datapath through fetch, decode, execute, memory and writeback, and emits one-cycle strobes for the IR, PC, register bank and data memory. It also exposes halt/run/step controls to the board monitor, so the core can be stopped at instruction boundaries.

---
 rtl/core_pkg.sv | 32 +++
 rtl/seq_decode.sv | 28 ++
 rtl/core_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I-subset multi-cycle core: sequencer state
// encodings, major opcodes, aluop encodings and the decoded path class.
package core_pkg;

  // Sequencer states (binary encoded)
  localparam logic [2:0] S_HALTED    = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control encodings
  localparam logic [1:0] ALUOP_ADD = 2'd0;
  localparam logic [1:0] ALUOP_SUB = 2'd1;
  localparam logic [1:0] ALUOP_RFN = 2'd2;
  localparam logic [1:0] ALUOP_IFN = 2'd3;

  // Path class: which states an instruction visits after EXECUTE
  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_LOAD   = 2'd1;
  localparam logic [1:0] CLS_STORE  = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode lookup: legality, path class, aluop and alusrc.
module seq_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic [1:0] cls,
  output logic [1:0] aluop,
  output logic       alusrc
);

  // Opcode to path/ALU control table; anything unlisted is illegal
  always_comb begin
    legal  = 1'b1;
    cls    = CLS_ALU;
    aluop  = ALUOP_ADD;
    alusrc = 1'b0;
    case (opcode)
      OP_RTYPE:  begin cls = CLS_ALU;    aluop = ALUOP_RFN; alusrc = 1'b0; end
      OP_IALU:   begin cls = CLS_ALU;    aluop = ALUOP_IFN; alusrc = 1'b1; end
      OP_LOAD:   begin cls = CLS_LOAD;   aluop = ALUOP_ADD; alusrc = 1'b1; end
      OP_STORE:  begin cls = CLS_STORE;  aluop = ALUOP_ADD; alusrc = 1'b1; end
      OP_BRANCH: begin cls = CLS_BRANCH; aluop = ALUOP_SUB; alusrc = 1'b0; end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32I-subset core. Steps the shared
// datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and supports
// halt/run/step from the board monitor at instruction boundaries.
// Optional feature macro: CORE_SEQUENCER_PERF_EN enables retire_cnt and
// cycle_cnt; when undefined both outputs are tied to zero.
module core_sequencer
  import core_pkg::*;
#(
  parameter bit RESET_RUN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        run_req,
  input  logic        step_req,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        memtoreg,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        pc_load,
  output logic        pc_branch,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retire_cnt,
  output logic [31:0] cycle_cnt
);

  localparam logic [2:0] S_RESET = RESET_RUN ? S_FETCH : S_HALTED;

  logic [2:0] state, state_nxt;
  logic [1:0] cls_q, aluop_q;
  logic       alusrc_q;
  logic       step_mode;
  logic       illegal_q;
  logic       dec_legal, dec_alusrc;
  logic [1:0] dec_cls, dec_aluop;
  logic       done, stop, resume;

  seq_decode u_dec (
    .opcode (opcode),
    .legal  (dec_legal),
    .cls    (dec_cls),
    .aluop  (dec_aluop),
    .alusrc (dec_alusrc)
  );

  assign stop   = halt_req | step_mode;
  assign resume = step_req | run_req;

  // Completion cycle of the current instruction (last state of its path).
  // A store completes in MEMORY on the cycle the access finishes, so this
  // term has to look at dmem_ready to keep pc_load one cycle wide.
  always_comb begin
    done = 1'b0;
    case (state)
      S_EXECUTE:   done = (cls_q == CLS_BRANCH);
      S_MEMORY:    done = (cls_q == CLS_STORE) & dmem_ready;
      S_WRITEBACK: done = 1'b1;
      default:     done = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED:  if (resume) state_nxt = S_FETCH;
      S_FETCH:   if (imem_ready) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = dec_legal ? S_EXECUTE : S_HALTED;
      S_EXECUTE: begin
        case (cls_q)
          CLS_BRANCH: state_nxt = stop ? S_HALTED : S_FETCH;
          CLS_LOAD,
          CLS_STORE:  state_nxt = S_MEMORY;
          default:    state_nxt = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (dmem_ready)
          state_nxt = (cls_q == CLS_LOAD) ? S_WRITEBACK :
                      (stop ? S_HALTED : S_FETCH);
      end
      S_WRITEBACK: state_nxt = stop ? S_HALTED : S_FETCH;
      default:     state_nxt = S_HALTED;
    endcase
  end

  // State register, latched decode results, step mode and sticky illegal
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      cls_q     <= CLS_ALU;
      aluop_q   <= ALUOP_ADD;
      alusrc_q  <= 1'b0;
      step_mode <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        cls_q    <= dec_cls;
        aluop_q  <= dec_aluop;
        alusrc_q <= dec_alusrc;
        if (!dec_legal) illegal_q <= 1'b1;
      end
      // step has priority: it arms step mode even if run is also present
      if (state == S_HALTED && resume) begin
        step_mode <= step_req;
        illegal_q <= 1'b0;
      end
    end
  end

  // Control outputs decoded from state and latched path class
  assign imem_req  = (state == S_FETCH);
  assign ir_load   = (state == S_FETCH) & imem_ready;
  assign dmem_req  = (state == S_MEMORY);
  assign dmem_we   = (state == S_MEMORY) & (cls_q == CLS_STORE);
  assign rf_we     = (state == S_WRITEBACK);
  assign memtoreg  = (state == S_WRITEBACK) & (cls_q == CLS_LOAD);
  assign alusrc    = (state == S_EXECUTE) & alusrc_q;
  assign aluop     = (state == S_EXECUTE) ? aluop_q : ALUOP_ADD;
  assign pc_load   = done;
  // zero is only meaningful in EXECUTE, the branch completion cycle
  assign pc_branch = (state == S_EXECUTE) & (cls_q == CLS_BRANCH) & zero;
  assign halted    = (state == S_HALTED);
  assign illegal   = illegal_q;

`ifdef CORE_SEQUENCER_PERF_EN
  logic [31:0] retire_q, cycle_q;

  // Performance counters; both wrap modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
      cycle_q  <= '0;
    end else begin
      if (done) retire_q <= retire_q + 32'd1;
      if (state != S_HALTED) cycle_q <= cycle_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
  assign cycle_cnt  = cycle_q;
`else
  assign retire_cnt = '0;
  assign cycle_cnt  = '0;
`endif

endmodule
